debug_breakpoint_unit: RTL and testbench
========================================

// Module: debug_breakpoint_unit
// PURPOSE
//  Parametrised debug-exception collector for the write stage. Supports NUM_BP
//  DRx-style breakpoints (code/write/read-write), single-step and task-switch trap.
//  Accumulates hits across multi-cycle and string instructions.
//  At instruction retirement it raises dbg_prepare and freezes per-breakpoint status
//  for the exception microcode (DR6 image).
// PARAMETERS
//  NUM_BP   4   number of breakpoint channels (1..8)
//  ADDR_W   32  linear address width
//  LEN_W    3   low-address mask width; bp_len is the aligned-length mask (0,1,3,7)
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              async active-low reset
//  bp_addr        in   NUM_BP*ADDR_W  breakpoint linear addresses, channel i at [i*ADDR_W +: ADDR_W]
//  bp_len         in   NUM_BP*LEN_W   length mask per channel
//  bp_rw          in   NUM_BP*2       00 exec, 01 write, 11 read/write, 10 reserved (never hits)
//  bp_enable      in   NUM_BP*2       {G,L} enable per channel; channel armed if either bit set
//  code_linear    in   ADDR_W         cs_base+eip of next instruction
//  code_in_limit  in   1              eip <= cs_limit
//  rflag          in   1              RF; suppresses code hits
//  tflag          in   1              TF value being written back
//  string_active  in   1              string instruction not yet complete
//  wr_address     in   ADDR_W         memory write linear address
//  wr_length      in   3              write length in bytes (1..4)
//  wr_ready       in   1              write accepted by memory (one-cycle pulse)
//  rd_hits        in   NUM_BP         read-breakpoint hits from execute, valid with ld
//  ld             in   1              write stage loads a new micro-op
//  finished       in   1              instruction retires this cycle
//  inhibit        in   1              interrupts/debug inhibited (MOV/POP SS shadow)
//  task_trap      in   1              task switch with T bit set
//  trap_clear     in   1              discard pending traps
//  dbg_prepare    out  1              retire-cycle request to enter debug exception
//  dbg_code       out  NUM_BP         captured code hits
//  dbg_write      out  NUM_BP         captured/accumulated write hits
//  dbg_read       out  NUM_BP         captured/accumulated read hits
//  dbg_step       out  1              captured single-step
//  dbg_task       out  1              captured task trap
// BEHAVIOUR
//  - All outputs except dbg_prepare are flops, reset to 0. dbg_prepare is combinational.
//  - Global disable: when all bp_enable bits are 0, code/read/write current hits are forced to 0.
//  - Write compare, 2-cycle pipeline:
//    - S1 registers wr_address and last = wr_address+wr_length-1.
//    - last is computed in ADDR_W+1 bits; on carry it saturates to all-ones (no wrap).
//    - S2 registers per channel hit_w[i] = armed[i] & bp_rw[i][0] & (S1.addr <= bp_addr|~len)
//      & (S1.last >= bp_addr&len), where len masks the low LEN_W bits.
//    - wr_ready arrives >= 2 cycles after wr_address is stable.
//  - dbg_write update, priority order:
//    - inhibit: hold
//    - trap_clear: 0
//    - wr_ready | dbg_prepare: dbg_write | hit_w
//    - finished: 0
//  - dbg_read update, priority order:
//    - inhibit | dbg_prepare: hold
//    - trap_clear: 0
//    - finished & ld: rd_hits
//    - finished: 0
//    - ld: dbg_read | rd_hits
//  - Code hit, combinational:
//    - code_hit[i] = finished & code_in_limit & ~rflag & ~string_active & armed[i]
//      & bp_rw[i]==00 & (bp_addr&len)==(code_linear&len).
//  - A channel is "active" when its hit bit is set and its bp_enable is nonzero.
//  - step_pend flop: trap_clear -> 0, else finished -> tflag.
//    So the step trap fires on the instruction after TF is set.
//  - dbg_prepare = finished & ~inhibit & (task_trap | step_pend | any active code/read/write).
//  - On dbg_prepare, latch:
//    - dbg_code <= code_hit, or 0 if no code channel is active
//    - dbg_step <= step_pend
//    - dbg_task <= task_trap
//  - Simultaneous events: trap_clear beats finished and ld.
//    inhibit beats trap_clear for dbg_read and dbg_write.
//  - Reset mid-operation clears the pipeline and all sticky state immediately (async).
// CONFIGURATION
//  DEBUG_HIT_COUNT_EN defined:
//    - Adds output hit_count (NUM_BP*8): per-channel 8-bit saturating counters, reset 0.
//    - A counter increments on each dbg_prepare whose captured code, read or write bit is set
//      for that channel; it sticks at 255.
//  DEBUG_HIT_COUNT_EN undefined: port and counters are absent; all other behaviour is identical.
// TESTING
//  1. Code: bp0 addr=0x1000, len=0, rw=00, en=01; finished with code_linear=0x1000
//     -> dbg_prepare=1 that cycle; next cycle dbg_code=0001. Repeat with rflag=1 -> no prepare.
//  2. Write: bp2 addr=0x2004, len=3, rw=01; write addr=0x2006, length=4, wr_ready 2 cycles later,
//     then finished -> dbg_write=0100, dbg_prepare=1. Repeat at addr 0x2008 -> no hit.
//  3. Wrap: write addr=0xFFFFFFFE, length=4; bp1 at 0xFFFFFFFF, rw=11 -> hit.
//     bp1 at 0x00000000 -> no hit (saturation).
//  4. String accumulate: three ld cycles with rd_hits=0001, 0010, 0000, then finished & ld with 0000
//     -> dbg_read=0000. Variant with string_active held and finished only at the end
//     -> OR 0011 retained for the prepare.
//  5. Step/task: finished with tflag=1, then next finished -> dbg_prepare, dbg_step=1.
//     trap_clear between them -> no prepare. task_trap & finished -> dbg_task=1.
//  6. Inhibit and reset: inhibit=1 with pending hits -> no prepare, dbg_read/dbg_write held.
//     rst_n low mid-pipeline -> all outputs 0 within the same cycle; hit_count=0 if enabled.

Source files
------------

// File: rtl/debug_breakpoint_unit.sv
// Write-stage debug exception collector: DRx-style breakpoints, single step and task trap.
// Optional per-channel saturating hit counters are built when DEBUG_HIT_COUNT_EN is defined.
module debug_breakpoint_unit #(
   parameter int NUM_BP = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
   input  logic [NUM_BP*LEN_W-1:0]  bp_len,
   input  logic [NUM_BP*2-1:0]      bp_rw,
   input  logic [NUM_BP*2-1:0]      bp_enable,
   input  logic [ADDR_W-1:0]        code_linear,
   input  logic                     code_in_limit,
   input  logic                     rflag,
   input  logic                     tflag,
   input  logic                     string_active,
   input  logic [ADDR_W-1:0]        wr_address,
   input  logic [2:0]               wr_length,
   input  logic                     wr_ready,
   input  logic [NUM_BP-1:0]        rd_hits,
   input  logic                     ld,
   input  logic                     finished,
   input  logic                     inhibit,
   input  logic                     task_trap,
   input  logic                     trap_clear,
   output logic                     dbg_prepare,
   output logic [NUM_BP-1:0]        dbg_code,
   output logic [NUM_BP-1:0]        dbg_write,
   output logic [NUM_BP-1:0]        dbg_read,
   output logic                     dbg_step,
   output logic                     dbg_task
`ifdef DEBUG_HIT_COUNT_EN
   ,
   output logic [NUM_BP*8-1:0]      hit_count
`endif
);

   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic                any_en;
   logic [NUM_BP-1:0]   armed;
   logic [NUM_BP-1:0]   code_hit;
   logic [NUM_BP-1:0]   hit_w_nxt;
   logic [NUM_BP-1:0]   hit_w;
   logic [NUM_BP-1:0]   hit_w_eff;
   logic [NUM_BP-1:0]   rd_eff;
   logic [NUM_BP-1:0]   write_nxt;
   logic [NUM_BP-1:0]   read_nxt;
   logic [ADDR_W:0]     last_sum;
   logic [ADDR_W-1:0]   last_sat;
   logic [ADDR_W-1:0]   s1_addr;
   logic [ADDR_W-1:0]   s1_last;
   logic                step_pend;

   assign any_en = |bp_enable;

   // Last byte touched by the write; a carry out of the address space pins it to the top.
   assign last_sum = {1'b0, wr_address} + {{(ADDR_W-2){1'b0}}, wr_length} - ONE;
   assign last_sat = last_sum[ADDR_W] ? {ADDR_W{1'b1}} : last_sum[ADDR_W-1:0];

   for (genvar g = 0; g < NUM_BP; g++) begin : g_ch
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] lmask;
      logic [ADDR_W-1:0] lo;
      logic [ADDR_W-1:0] hi;
      logic [1:0]        rw;

      assign base  = bp_addr[g*ADDR_W +: ADDR_W];
      assign lmask = {{(ADDR_W-LEN_W){1'b0}}, bp_len[g*LEN_W +: LEN_W]};
      assign lo    = base & ~lmask;
      assign hi    = base | lmask;
      assign rw    = bp_rw[g*2 +: 2];

      assign armed[g]     = |bp_enable[g*2 +: 2];
      assign hit_w_nxt[g] = armed[g] & rw[0] & (s1_addr <= hi) & (s1_last >= lo);
      assign code_hit[g]  = any_en & finished & code_in_limit & ~rflag & ~string_active
                            & armed[g] & (rw == 2'b00) & ((code_linear & ~lmask) == lo);
   end

   assign hit_w_eff = any_en ? hit_w : '0;
   assign rd_eff    = any_en ? rd_hits : '0;

   assign dbg_prepare = finished & ~inhibit
                        & (task_trap | step_pend | (|code_hit)
                           | (|(dbg_read & armed)) | (|(dbg_write & armed)));

   always_comb begin
      write_nxt = dbg_write;
      if (!inhibit) begin
         if (trap_clear)                    write_nxt = '0;
         else if (wr_ready || dbg_prepare)  write_nxt = dbg_write | hit_w_eff;
         else if (finished)                 write_nxt = '0;
      end
   end

   // Reads accumulate across micro-ops and stay frozen while the prepare is taken.
   always_comb begin
      read_nxt = dbg_read;
      if (!(inhibit || dbg_prepare)) begin
         if (trap_clear)              read_nxt = '0;
         else if (finished && ld)     read_nxt = rd_eff;
         else if (finished)           read_nxt = '0;
         else if (ld)                 read_nxt = dbg_read | rd_eff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_addr <= '0;
         s1_last <= '0;
         hit_w   <= '0;
      end else begin
         s1_addr <= wr_address;
         s1_last <= last_sat;
         hit_w   <= hit_w_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_write <= '0;
         dbg_read  <= '0;
         dbg_code  <= '0;
         dbg_step  <= 1'b0;
         dbg_task  <= 1'b0;
         step_pend <= 1'b0;
      end else begin
         dbg_write <= write_nxt;
         dbg_read  <= read_nxt;
         if (trap_clear)    step_pend <= 1'b0;
         else if (finished) step_pend <= tflag;
         if (dbg_prepare) begin
            dbg_code <= code_hit;
            dbg_step <= step_pend;
            dbg_task <= task_trap;
         end
      end
   end

`ifdef DEBUG_HIT_COUNT_EN
   logic [NUM_BP-1:0] captured;
   assign captured = code_hit | read_nxt | write_nxt;

   for (genvar c = 0; c < NUM_BP; c++) begin : g_cnt
      logic [7:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt <= '0;
         else if (dbg_prepare && captured[c] && (cnt != 8'hFF))
            cnt <= cnt + 8'd1;
      end
      assign hit_count[c*8 +: 8] = cnt;
   end
`endif

endmodule

// File: tb/tb_debug_breakpoint_unit.sv
// Bench for debug_breakpoint_unit: directed scenarios then random traffic against a
// range/arithmetic reference model.
module tb_debug_breakpoint_unit;
   localparam int NB = 4;
   localparam int AW = 32;
   localparam int LW = 3;

   logic            clk, rst_n;
   logic [NB*AW-1:0] bp_addr;
   logic [NB*LW-1:0] bp_len;
   logic [NB*2-1:0]  bp_rw, bp_enable;
   logic [AW-1:0]   code_linear, wr_address;
   logic            code_in_limit, rflag, tflag, string_active;
   logic [2:0]      wr_length;
   logic            wr_ready, ld, finished, inhibit, task_trap, trap_clear;
   logic [NB-1:0]   rd_hits;
   logic            dbg_prepare, dbg_step, dbg_task;
   logic [NB-1:0]   dbg_code, dbg_write, dbg_read;
`ifdef DEBUG_HIT_COUNT_EN
   logic [NB*8-1:0] hit_count;
`endif

   logic [31:0] cfg_addr[NB];
   logic [2:0]  cfg_len[NB];
   logic [1:0]  cfg_rw[NB];
   logic [1:0]  cfg_en[NB];

   logic [NB-1:0] m_code, m_write, m_read;
   logic          m_step_pend, m_step, m_task;
   int            n_vec, n_err;
   logic [31:0]   pool[6];

   debug_breakpoint_unit #(.NUM_BP(NB), .ADDR_W(AW), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .bp_addr(bp_addr), .bp_len(bp_len), .bp_rw(bp_rw),
      .bp_enable(bp_enable), .code_linear(code_linear), .code_in_limit(code_in_limit),
      .rflag(rflag), .tflag(tflag), .string_active(string_active), .wr_address(wr_address),
      .wr_length(wr_length), .wr_ready(wr_ready), .rd_hits(rd_hits), .ld(ld),
      .finished(finished), .inhibit(inhibit), .task_trap(task_trap), .trap_clear(trap_clear),
      .dbg_prepare(dbg_prepare), .dbg_code(dbg_code), .dbg_write(dbg_write),
      .dbg_read(dbg_read), .dbg_step(dbg_step), .dbg_task(dbg_task)
`ifdef DEBUG_HIT_COUNT_EN
      , .hit_count(hit_count)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   always_comb begin
      bp_addr = '0; bp_len = '0; bp_rw = '0; bp_enable = '0;
      for (int i = 0; i < NB; i++) begin
         bp_addr[i*AW +: AW] = cfg_addr[i];
         bp_len[i*LW +: LW]  = cfg_len[i];
         bp_rw[i*2 +: 2]     = cfg_rw[i];
         bp_enable[i*2 +: 2] = cfg_en[i];
      end
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: breakpoints are aligned blocks of (len+1) bytes
   function automatic bit any_en();
      bit r = 0;
      for (int i = 0; i < NB; i++) if (cfg_en[i] != 0) r = 1;
      return r;
   endfunction

   function automatic longint unsigned blk_lo(int i);
      longint unsigned sz = longint'(cfg_len[i]) + 1;
      return (longint'(cfg_addr[i]) / sz) * sz;
   endfunction

   function automatic logic [NB-1:0] model_wr();
      logic [NB-1:0] r = '0;
      longint unsigned lo, hi, blo, bhi;
      lo = longint'(wr_address);
      hi = lo + longint'(wr_length) - 1;
      if (hi > 64'hFFFF_FFFF) hi = 64'hFFFF_FFFF;
      for (int i = 0; i < NB; i++) begin
         blo = blk_lo(i);
         bhi = blo + longint'(cfg_len[i]);
         r[i] = any_en() && (cfg_en[i] != 0) && (cfg_rw[i] == 2'b01 || cfg_rw[i] == 2'b11)
                && lo <= bhi && hi >= blo;
      end
      return r;
   endfunction

   function automatic logic [NB-1:0] model_code();
      logic [NB-1:0] r = '0;
      longint unsigned sz;
      for (int i = 0; i < NB; i++) begin
         sz = longint'(cfg_len[i]) + 1;
         r[i] = any_en() && finished && code_in_limit && !rflag && !string_active
                && (cfg_en[i] != 0) && cfg_rw[i] == 2'b00
                && (longint'(code_linear) / sz) == (longint'(cfg_addr[i]) / sz);
      end
      return r;
   endfunction

   function automatic bit model_prep(logic [NB-1:0] ch);
      bit act = 0;
      for (int i = 0; i < NB; i++)
         if (cfg_en[i] != 0 && (ch[i] || m_read[i] || m_write[i])) act = 1;
      return finished && !inhibit && (task_trap || m_step_pend || act);
   endfunction

   task automatic model_reset();
      m_code = '0; m_write = '0; m_read = '0;
      m_step_pend = 0; m_step = 0; m_task = 0;
   endtask

   // driver tasks
   task automatic clear_ctl();
      ld = 0; finished = 0; wr_ready = 0; inhibit = 0; trap_clear = 0; task_trap = 0;
      tflag = 0; rflag = 0; string_active = 0; code_in_limit = 1; rd_hits = '0;
   endtask

   task automatic set_bp(int i, logic [31:0] a, logic [2:0] l, logic [1:0] rw, logic [1:0] en);
      cfg_addr[i] = a; cfg_len[i] = l; cfg_rw[i] = rw; cfg_en[i] = en;
   endtask

   task automatic disable_all();
      for (int i = 0; i < NB; i++) set_bp(i, 32'h0000_3000, 3'd0, 2'b10, 2'b00);
   endtask

   // inputs are set just after a negedge; check, clock once, check state
   task automatic run_cycle();
      logic [NB-1:0] wh, ch, rh;
      bit p;
      #1;
      wh = model_wr();
      ch = model_code();
      rh = any_en() ? rd_hits : '0;
      p  = model_prep(ch);
      check("prepare", {31'b0, dbg_prepare}, {31'b0, p});
      @(posedge clk);
      if (!inhibit) begin
         if (trap_clear)              m_write = '0;
         else if (wr_ready || p)      m_write = m_write | wh;
         else if (finished)           m_write = '0;
      end
      if (!(inhibit || p)) begin
         if (trap_clear)              m_read = '0;
         else if (finished && ld)     m_read = rh;
         else if (finished)           m_read = '0;
         else if (ld)                 m_read = m_read | rh;
      end
      if (p) begin
         m_code = ch; m_step = m_step_pend; m_task = task_trap;
      end
      if (trap_clear)    m_step_pend = 0;
      else if (finished) m_step_pend = tflag;
      @(negedge clk);
      check("code",  {28'b0, dbg_code},  {28'b0, m_code});
      check("write", {28'b0, dbg_write}, {28'b0, m_write});
      check("read",  {28'b0, dbg_read},  {28'b0, m_read});
      check("step",  {31'b0, dbg_step},  {31'b0, m_step});
      check("task",  {31'b0, dbg_task},  {31'b0, m_task});
   endtask

   task automatic cyc_expect(logic p);
      #1;
      check("d_prep", {31'b0, dbg_prepare}, {31'b0, p});
      run_cycle();
      clear_ctl();
   endtask

   task automatic idle(int n);
      clear_ctl();
      repeat (n) run_cycle();
   endtask

   task automatic check_zero(string tag);
      check({tag, "_code"},  {28'b0, dbg_code},  32'h0);
      check({tag, "_write"}, {28'b0, dbg_write}, 32'h0);
      check({tag, "_read"},  {28'b0, dbg_read},  32'h0);
      check({tag, "_step"},  {31'b0, dbg_step},  32'h0);
      check({tag, "_task"},  {31'b0, dbg_task},  32'h0);
      check({tag, "_prep"},  {31'b0, dbg_prepare}, 32'h0);
   endtask

   task automatic reset_mid();
      clear_ctl();
      #2 rst_n = 0;
      #1 check_zero("rst_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1;
      idle(2);
   endtask

   task automatic randomize_cfg();
      for (int i = 0; i < NB; i++) begin
         int k = $urandom_range(0, 3);
         cfg_addr[i] = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 8)) - 32'd4;
         cfg_len[i]  = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd3 : 3'd7;
         cfg_rw[i]   = 2'($urandom_range(0, 3));
         cfg_en[i]   = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) for (int i = 0; i < NB; i++) cfg_en[i] = 2'b00;
      wr_address = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 10)) - 32'd5;
      wr_length  = 3'($urandom_range(1, 4));
      idle(2);
   endtask

   task automatic random_cycle();
      ld            = ($urandom_range(0, 1) == 0);
      finished      = ($urandom_range(0, 2) == 0);
      wr_ready      = ($urandom_range(0, 3) == 0);
      inhibit       = ($urandom_range(0, 7) == 0);
      trap_clear    = ($urandom_range(0, 9) == 0);
      task_trap     = ($urandom_range(0, 9) == 0);
      tflag         = ($urandom_range(0, 3) == 0);
      rflag         = ($urandom_range(0, 3) == 0);
      string_active = ($urandom_range(0, 3) == 0);
      code_in_limit = ($urandom_range(0, 7) != 0);
      rd_hits       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) code_linear = $urandom;
      else code_linear = cfg_addr[$urandom_range(0, NB-1)] + 32'($urandom_range(0, 8)) - 32'd4;
      run_cycle();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      pool = '{32'h0000_1000, 32'h0000_2004, 32'hFFFF_FFFF, 32'h0000_0000,
               32'hFFFF_FFF8, 32'h0000_3000};
      disable_all();
      clear_ctl();
      code_linear = '0; wr_address = 32'h0000_8000; wr_length = 3'd1;
      rst_n = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_zero("rst");
      rst_n = 1;
      idle(2);

      // code breakpoint, then suppressed by RF
      set_bp(0, 32'h0000_1000, 3'd0, 2'b00, 2'b01);
      idle(2);
      finished = 1; code_linear = 32'h0000_1000;
      cyc_expect(1);
      check("d_code", {28'b0, dbg_code}, 32'h1);
      finished = 1; code_linear = 32'h0000_1000; rflag = 1;
      cyc_expect(0);

      // write overlap hit and miss
      disable_all();
      set_bp(2, 32'h0000_2004, 3'd3, 2'b01, 2'b10);
      wr_address = 32'h0000_2006; wr_length = 3'd4;
      idle(2);
      wr_ready = 1; run_cycle(); clear_ctl();
      check("d_write_hit", {28'b0, dbg_write}, 32'h4);
      finished = 1;
      cyc_expect(1);
      trap_clear = 1; run_cycle(); clear_ctl();
      wr_address = 32'h0000_2008;
      idle(2);
      wr_ready = 1; run_cycle(); clear_ctl();
      check("d_write_miss", {28'b0, dbg_write}, 32'h0);

      // write near top of address space saturates instead of wrapping
      disable_all();
      set_bp(1, 32'hFFFF_FFFF, 3'd0, 2'b11, 2'b01);
      wr_address = 32'hFFFF_FFFE; wr_length = 3'd4;
      idle(2);
      wr_ready = 1; run_cycle(); clear_ctl();
      check("d_wrap_hit", {28'b0, dbg_write}, 32'h2);
      trap_clear = 1; run_cycle();
      set_bp(1, 32'h0000_0000, 3'd0, 2'b11, 2'b01);
      idle(2);
      wr_ready = 1; run_cycle(); clear_ctl();
      check("d_wrap_miss", {28'b0, dbg_write}, 32'h0);

      // string read accumulation, armed channels then unarmed channels
      disable_all();
      set_bp(0, 32'h0000_1000, 3'd0, 2'b11, 2'b01);
      set_bp(1, 32'h0000_1004, 3'd0, 2'b11, 2'b01);
      wr_address = 32'h0000_8000; wr_length = 3'd1;
      idle(2);
      foreach (pool[k]) if (k < 3) begin
         string_active = 1; ld = 1;
         rd_hits = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000;
         run_cycle();
      end
      clear_ctl();
      finished = 1;
      cyc_expect(1);
      check("d_read_keep", {28'b0, dbg_read}, 32'h3);
      trap_clear = 1; run_cycle();
      disable_all();
      set_bp(2, 32'h0000_3000, 3'd0, 2'b01, 2'b01);
      idle(2);
      foreach (pool[k]) if (k < 3) begin
         ld = 1;
         rd_hits = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000;
         run_cycle();
      end
      clear_ctl();
      finished = 1; ld = 1;
      cyc_expect(0);
      check("d_read_clear", {28'b0, dbg_read}, 32'h0);

      // single step and task trap
      disable_all();
      idle(2);
      finished = 1; tflag = 1; cyc_expect(0);
      finished = 1;            cyc_expect(1);
      check("d_step", {31'b0, dbg_step}, 32'h1);
      finished = 1; tflag = 1; cyc_expect(0);
      trap_clear = 1; run_cycle(); clear_ctl();
      finished = 1;            cyc_expect(0);
      finished = 1; task_trap = 1; cyc_expect(1);
      check("d_task", {31'b0, dbg_task}, 32'h1);
      check("d_task_step", {31'b0, dbg_step}, 32'h0);

      // inhibit holds pending hits; reset wipes everything
      set_bp(0, 32'h0000_1000, 3'd0, 2'b11, 2'b01);
      wr_address = 32'h0000_1000; wr_length = 3'd1;
      idle(2);
      wr_ready = 1; ld = 1; rd_hits = 4'b0001; run_cycle(); clear_ctl();
      finished = 1; inhibit = 1; ld = 1; trap_clear = 1; cyc_expect(0);
      check("d_read_inh",  {28'b0, dbg_read},  32'h1);
      check("d_write_inh", {28'b0, dbg_write}, 32'h1);
      reset_mid();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 7) == 0) randomize_cfg();
         else if ($urandom_range(0, 63) == 0) reset_mid();
         else random_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
